// File: rtl/jts16_vidcap.sv
// jts16_vidcap: captures one active frame of the mixer's RGB output and streams
// it, one word per pixel, to external memory through a small FIFO and a req/ack port.
//
// state | meaning
// IDLE  | waiting for cap_req
// ARM   | capture requested, waiting for LVBL to fall (top of next frame)
// SYNC  | waiting for the first active pixel of the frame
// CAP   | pushing active pixels into the FIFO
// DRAIN | frame ended, waiting for FIFO and write port to empty
module jts16_vidcap #(
    parameter int AW      = 17,
    parameter int FIFO_AW = 4,
    parameter int BASE    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic          LVBL,
    input  logic [4:0]    red,
    input  logic [4:0]    green,
    input  logic [4:0]    blue,
    input  logic          cap_req,
    output logic          busy,
    output logic          done,
    output logic          ovf,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic          mem_we,
    input  logic          mem_ok
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = AW + 16;
    localparam logic [FIFO_AW:0] FILL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] FILL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [AW-1:0]    BASE_ADDR = AW'(BASE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SYNC,
        ST_CAP,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               lvbl_q, lvbl_d;
    logic [AW-1:0]      pix_cnt_q, pix_cnt_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   fill_q, fill_d;
    logic               mem_we_q, mem_we_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic [15:0]        mem_din_q, mem_din_d;
    logic [EW-1:0]      fifo_mem_q [DEPTH];

    logic               active, vfall, capture, fifo_full, push, pop, drop;
    logic [FIFO_AW-1:0] head_idx;
    logic [EW-1:0]      push_entry;

    always_comb begin
        active     = pxl_cen & LHBL & LVBL;
        vfall      = lvbl_q & ~LVBL;
        lvbl_d     = LVBL;
        pop        = mem_we_q & mem_ok;
        fifo_full  = (fill_q == FILL_FULL);
        capture    = active && (state_q == ST_SYNC || state_q == ST_CAP);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push       = capture && (!fifo_full || pop);
        drop       = capture && fifo_full && !pop;
        push_entry = {BASE_ADDR + pix_cnt_q, 1'b0, red, green, blue};
        head_idx   = pop ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_ONE;
            2'b01:   fill_d = fill_q - FILL_ONE;
            default: fill_d = fill_q;
        endcase

        // the presented word stays in the FIFO until acknowledged
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        if (!mem_we_q) begin
            if (fill_q != '0) begin
                mem_we_d                = 1'b1;
                {mem_addr_d, mem_din_d} = fifo_mem_q[head_idx];
            end
        end else if (pop) begin
            if (fill_q > FILL_ONE) begin
                {mem_addr_d, mem_din_d} = fifo_mem_q[head_idx];
            end else begin
                mem_we_d = 1'b0;
            end
        end

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q | drop;
        pix_cnt_d = capture ? pix_cnt_q + AW'(1) : pix_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_req) begin
                    state_d   = ST_ARM;
                    busy_d    = 1'b1;
                    ovf_d     = 1'b0;
                    pix_cnt_d = '0;
                end
            end
            ST_ARM:   if (vfall)  state_d = ST_SYNC;
            ST_SYNC:  if (active) state_d = ST_CAP;
            ST_CAP:   if (vfall)  state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (fill_q == '0 && !mem_we_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lvbl_q     <= 1'b0;
            pix_cnt_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            lvbl_q     <= lvbl_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
endmodule

// File: tb/tb_jts16_vidcap.sv
// tb_jts16_vidcap: directed bench for the frame-capture sink; compares captured
// writes against hand-built expectations of address and {0,r,g,b} data.
module tb_jts16_vidcap;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst, pxl_cen, LHBL, LVBL, cap_req, mem_ok;
    logic [4:0]    red, green, blue;
    logic          busy, done, ovf, mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;

    always #5 clk = ~clk;

    jts16_vidcap #(.AW(AW), .FIFO_AW(4), .BASE(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .cap_req  (cap_req),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_ok   (mem_ok)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write monitor, sampled on the falling edge
    logic [AW+15:0] got_q[$];
    int             wr_cnt = 0;
    int             done_cnt = 0;
    int             done_busy_err = 0;
    int             hold_err = 0;
    logic           hold_pending = 1'b0;
    logic [AW+16:0] hold_val = '0;
    logic           busy_prev = 1'b0;

    always @(negedge clk) begin
        if (hold_pending && {mem_we, mem_addr, mem_din} !== hold_val) hold_err++;
        hold_pending = mem_we && !mem_ok && !rst;
        hold_val     = {mem_we, mem_addr, mem_din};
        if (mem_we && mem_ok) begin
            got_q.push_back({mem_addr, mem_din});
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            if (busy || !busy_prev) done_busy_err++;
        end
        busy_prev = busy;
    end

    logic [AW+15:0] exp_q[$];
    int             got_idx = 0;
    int             k = 0;
    int             d0;

    function automatic logic [14:0] pix_rgb(input int idx);
        logic [4:0] r, g, b;
        r = 5'(31 - idx);
        g = 5'(idx);
        b = 5'(idx + 1);
        return {r, g, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vid_line(input int np, input int per, input int keep);
        LHBL = 1'b1;
        for (int i = 0; i < np; i++) begin
            {red, green, blue} = pix_rgb(k);
            pxl_cen = 1'b1;
            if (i < keep) exp_q.push_back({AW'(k), 1'b0, pix_rgb(k)});
            k++;
            tick(1);
            pxl_cen = 1'b0;
            tick(per - 1);
        end
        LHBL = 1'b0;
        tick(6);
    endtask

    task automatic vblank(input int n);
        LVBL    = 1'b0;
        LHBL    = 1'b0;
        pxl_cen = 1'b0;
        tick(n);
        LVBL = 1'b1;
        k    = 0;
    endtask

    task automatic pulse_cap();
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && busy; i++) @(negedge clk);
        chk("drain_idle", busy, 0);
        tick(2);
    endtask

    task automatic compare_writes(input string tag);
        int             n_got, n;
        logic [AW+15:0] g, e;
        n_got = got_q.size() - got_idx;
        chk({tag, "_count"}, n_got, exp_q.size());
        n = (n_got < exp_q.size()) ? n_got : exp_q.size();
        for (int i = 0; i < n; i++) begin
            g = got_q[got_idx + i];
            e = exp_q[i];
            chk({tag, "_addr"}, g[AW+15:16], e[AW+15:16]);
            chk({tag, "_data"}, g[15:0], e[15:0]);
        end
        got_idx = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW+15:0] first;
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
        cap_req = 1'b0; mem_ok = 1'b1; {red, green, blue} = '0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);

        // idle: blanking activity without a request
        LVBL = 1'b1;
        vid_line(4, 1, 0);
        vid_line(4, 1, 0);
        vblank(5);
        vid_line(4, 1, 0);
        vblank(5);
        chk("idle_busy", busy, 0);
        chk("idle_writes", wr_cnt, 0);
        chk("idle_done", done_cnt, 0);

        // 4x2 frame, request mid-frame
        vid_line(4, 1, 0);
        pulse_cap();
        vid_line(4, 1, 0);
        @(negedge clk);
        chk("arm_busy", busy, 1);
        chk("arm_no_wr", wr_cnt, 0);
        d0 = done_cnt;
        vblank(6);
        vid_line(4, 1, 4);
        vid_line(4, 1, 4);
        vblank(6);
        wait_idle(100);
        first = (got_q.size() > 0) ? got_q[0] : '0;
        chk("first_din", first[15:0], 16'h7C01);
        compare_writes("frame");
        chk("frame_done", done_cnt - d0, 1);
        chk("frame_ovf", ovf, 0);

        // back-pressure for 20 cycles during a 16-pixel line
        d0 = done_cnt;
        pulse_cap();
        vblank(6);
        fork
            vid_line(16, 2, 16);
            begin
                tick(5);
                mem_ok = 1'b0;
                tick(20);
                mem_ok = 1'b1;
            end
        join
        vblank(6);
        wait_idle(200);
        compare_writes("bp");
        chk("bp_ovf", ovf, 0);
        chk("bp_done", done_cnt - d0, 1);
        chk("bp_hold", hold_err, 0);

        // overflow: no acks for a whole 40-pixel line
        d0 = done_cnt;
        pulse_cap();
        vblank(6);
        mem_ok = 1'b0;
        vid_line(40, 2, 16);
        @(negedge clk);
        chk("ovf_set", ovf, 1);
        mem_ok = 1'b1;
        vid_line(4, 2, 4);
        vblank(6);
        wait_idle(200);
        compare_writes("ovf");
        chk("ovf_sticky", ovf, 1);
        chk("ovf_done", done_cnt - d0, 1);

        // reset with entries queued
        d0 = done_cnt;
        pulse_cap();
        @(negedge clk);
        chk("ovf_clr", ovf, 0);
        vblank(6);
        mem_ok = 1'b0;
        vid_line(5, 1, 0);
        @(negedge clk);
        chk("prerst_we", mem_we, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_we", mem_we, 0);
        chk("midrst_busy", busy, 0);
        mem_ok = 1'b1;
        tick(22);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_wr", got_q.size() - got_idx, 0);
        vblank(6);

        // re-trigger during capture is ignored
        d0 = done_cnt;
        pulse_cap();
        vblank(6);
        vid_line(4, 1, 4);
        pulse_cap();
        vid_line(4, 1, 4);
        vblank(6);
        wait_idle(100);
        vid_line(4, 1, 0);
        vblank(6);
        vid_line(4, 1, 0);
        vblank(6);
        tick(2);
        compare_writes("retrig");
        chk("retrig_done", done_cnt - d0, 1);
        chk("retrig_busy", busy, 0);

        chk("hold_total", hold_err, 0);
        chk("done_busy_fall", done_busy_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
